button_encoder_4x2: RTL and testbench
=====================================

# button_encoder_4x2

Debounced 4-key to 2-bit code encoder; the input-side counterpart of the FND digit-select decoder. It takes four active-low push-button lines and synchronizes and debounces them. It then priority-encodes the pressed key into a 2-bit index and emits press/release event pulses. It sits between the board buttons and the display control logic, using the same 2-bit index convention as the digit select (index 0 corresponds to bit 0 low).

## Interface
- DEBOUNCE_CYCLES, default 100000: consecutive cycles a changed input must hold before it is accepted; must be ≥ 2.
- REPEAT_DELAY, default 50000000: hold cycles before the first auto-repeat press pulse; used only with BTN_REPEAT_EN.
- REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat pulses; used only with BTN_REPEAT_EN.
- i_clk  input  1  single clock; all state is updated on its rising edge.
- i_reset  input  1  reset; asynchronous and active-high.
- i_btn  input  4  raw button lines, active-low, asynchronous to i_clk.
- o_key  output  2  encoded index of the pressed key; reset 2'b00.
- o_valid  output  1  level, high while at least one debounced key is pressed; reset 0.
- o_multi  output  1  level, high while two or more debounced keys are pressed; reset 0.
- o_press  output  1  one-cycle pulse on a press event, including repeats; reset 0.
- o_release  output  1  one-cycle pulse when the last key is released; reset 0.

## Operation
- **Synchronizer:** 2-flop synchronizer on i_btn. Both stages reset to 4'b1111.
- **Debounce:** r_stable resets to 4'b1111 and the counter resets to 0.
  - When sync ≠ r_stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, r_stable takes sync and the counter clears.
  - When sync = r_stable, the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is discarded.
  - The whole 4-bit vector shares one counter. Any change to sync mid-count does not restart the count; only a return to r_stable does.
- **Encode (combinational on r_stable):**
  - any = at least one bit is 0.
  - code = lowest index whose bit is 0.
  - multi = two or more bits are 0.
- **FSM states:** IDLE, HELD, and REPEAT (REPEAT exists only with BTN_REPEAT_EN).
  - IDLE → HELD when any=1. Pulse o_press and load o_key=code.
  - HELD → IDLE when any=0. Pulse o_release; o_key holds its last value.
  - HELD with a code change while any=1: o_key updates and no pulse is issued. With BTN_REPEAT_EN, the hold counter restarts.
  - REPEAT → IDLE when any=0, with o_release. A code change returns the FSM to HELD and restarts the hold counter.
- **Register updates:**
  - o_valid and o_multi are registered from any and multi.
  - o_key is registered and updates only in HELD or REPEAT, or on entry to HELD.

## Timing
- Latency from a clean i_btn edge to the r_stable update: 2 + DEBOUNCE_CYCLES cycles.
- o_press, o_valid, o_key and o_release appear 1 cycle after the r_stable update.
- o_press and o_release are never high in the same cycle. Each is exactly 1 cycle wide.
- Asynchronous reset at any point, including mid-debounce or mid-repeat:
  - All outputs go to their reset values immediately.
  - The FSM goes to IDLE.
  - After reset deasserts, a key already held produces o_press after 2 + DEBOUNCE_CYCLES + 1 cycles.
- Counter widths are $clog2 of the respective parameter. Counters saturate and never wrap.

## Configuration
- Macro BTN_REPEAT_EN.
- **Defined:**
  - HELD counts cycles. At REPEAT_DELAY it pulses o_press and enters REPEAT.
  - REPEAT pulses o_press every REPEAT_PERIOD cycles while the code is unchanged.
- **Undefined:**
  - No REPEAT state and no hold counter.
  - Exactly one o_press per IDLE→HELD transition.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.

## Structure
- **Shared package btn_pkg:**
  - FSM state encoding (ST_IDLE, ST_HELD, ST_REPEAT).
  - Key index constants KEY0..KEY3 = 2'd0..2'd3, shared with the digit-select convention.
  - The all-released constant BTN_NONE = 4'b1111.
- **Sub-module:** btn_debounce, which contains the synchronizer, r_stable and the counter, parameterized by width and DEBOUNCE_CYCLES. The encoder and FSM stay in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4; the repeat scenario also uses REPEAT_DELAY=20 and REPEAT_PERIOD=8.
- **Clean press and release:** i_btn 4'b1111→4'b1011, held 10 cycles, then 4'b1111 → o_press pulse with o_key=2'd2 and o_valid=1 at cycle 7. o_release pulse 7 cycles after release, with o_valid=0.
- **Glitch rejection:** i_btn=4'b1110 for 3 cycles, then 4'b1111 → no o_press; o_valid stays 0.
- **Multi-key priority:** i_btn=4'b0111 held, then 4'b0101 → o_key=3 with one o_press. Then o_key=1 and o_multi=1 with no second press. Releasing to 4'b0111 gives o_key=3 and o_multi=0.
- **Reset mid-operation:** assert i_reset asynchronously while HELD and while the debounce count is at 2 → all outputs 0 in the same cycle. After deassert with 4'b1110 still applied, o_press occurs 7 cycles later.
- **BTN_REPEAT_EN defined:** hold 4'b1101 for 60 cycles → o_press at entry to HELD, then +20, +28, +36, …, with o_key=1 throughout. Without the macro, the same stimulus gives exactly one o_press.

Source files
------------

// File: rtl/button_encoder_4x2_pkg.sv
// Shared button/digit-select definitions: FSM states, key index constants and
// small encode helpers used by the button encoder.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  // Index 0 means bit 0 low, matching the digit-select decoder.
  localparam logic [1:0] KEY0 = 2'd0;
  localparam logic [1:0] KEY1 = 2'd1;
  localparam logic [1:0] KEY2 = 2'd2;
  localparam logic [1:0] KEY3 = 2'd3;

  localparam logic [3:0] BTN_NONE = 4'b1111;

  function automatic logic [1:0] btn_code(logic [3:0] b);
    btn_code = KEY0;
    for (int i = 3; i >= 0; i--)
      if (!b[i]) btn_code = 2'(i);
  endfunction

  // Two or more pressed: clearing the lowest set bit of the pressed mask leaves something.
  function automatic logic btn_multi(logic [3:0] b);
    logic [3:0] p;
    p = ~b;
    return (p & (p - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/button_encoder_4x2_if.sv
// Button encoder bus: raw active-low keys in, encoded key and event pulses out.
interface button_encoder_4x2_if;
  logic [3:0] i_btn;
  logic [1:0] o_key;
  logic       o_valid;
  logic       o_multi;
  logic       o_press;
  logic       o_release;

  modport master (output i_btn, input o_key, o_valid, o_multi, o_press, o_release);
  modport slave  (input i_btn, output o_key, o_valid, o_multi, o_press, o_release);
endinterface

// File: rtl/button_encoder_4x2_debounce.sv
// Two-flop synchronizer plus a shared-counter debouncer for an active-low vector.
module btn_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1, sync;
  logic [CW-1:0]    cnt;

  // One counter for the whole vector: only a return to the stable value restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '1;
      sync   <= '1;
      stable <= '1;
      cnt    <= '0;
    end else begin
      s1   <= raw;
      sync <= s1;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/button_encoder_4x2.sv
// Debounced 4-key priority encoder with press/release pulses.
// Optional auto-repeat of o_press while held: define BTN_REPEAT_EN.
module button_encoder_4x2
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  button_encoder_4x2_if.slave  bus
);
  logic [3:0] stable;
  logic       any, multi;
  logic [1:0] code;
  btn_state_e state;

  btn_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk   (i_clk),
    .rst   (i_reset),
    .raw   (bus.i_btn),
    .stable(stable)
  );

  assign any   = (stable != BTN_NONE);
  assign code  = btn_code(stable);
  assign multi = btn_multi(stable);

`ifdef BTN_REPEAT_EN
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;
  logic [HW-1:0] hold_cnt;
`else
  logic unused_rpt;
  assign unused_rpt = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      bus.o_key     <= KEY0;
      bus.o_valid   <= 1'b0;
      bus.o_multi   <= 1'b0;
      bus.o_press   <= 1'b0;
      bus.o_release <= 1'b0;
`ifdef BTN_REPEAT_EN
      hold_cnt      <= '0;
`endif
    end else begin
      bus.o_valid   <= any;
      bus.o_multi   <= multi;
      bus.o_press   <= 1'b0;
      bus.o_release <= 1'b0;
      case (state)
        ST_IDLE: if (any) begin
          state       <= ST_HELD;
          bus.o_press <= 1'b1;
          bus.o_key   <= code;
`ifdef BTN_REPEAT_EN
          hold_cnt    <= '0;
`endif
        end
        ST_HELD: begin
          if (!any) begin
            state         <= ST_IDLE;
            bus.o_release <= 1'b1;
          end else if (code != bus.o_key) begin
            bus.o_key <= code;
`ifdef BTN_REPEAT_EN
            hold_cnt  <= '0;
          end else if (hold_cnt == HW'(REPEAT_DELAY - 1)) begin
            state       <= ST_REPEAT;
            bus.o_press <= 1'b1;
            hold_cnt    <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end
`ifdef BTN_REPEAT_EN
        ST_REPEAT: begin
          if (!any) begin
            state         <= ST_IDLE;
            bus.o_release <= 1'b1;
          end else if (code != bus.o_key) begin
            state     <= ST_HELD;
            bus.o_key <= code;
            hold_cnt  <= '0;
          end else if (hold_cnt == HW'(REPEAT_PERIOD - 1)) begin
            bus.o_press <= 1'b1;
            hold_cnt    <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_button_encoder_4x2.sv
// Scoreboard bench for button_encoder_4x2: press/release events are predicted
// with their cycle when stimulus is driven and matched as the DUT emits them.
module tb_button_encoder_4x2;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int LAT = DB + 3;

  logic clk, rst;
  int   cyc = 0;
  int   n_chk = 0, n_err = 0;

  typedef struct {
    int         cyc;
    bit         press;
    logic [1:0] key;
    bit         valid;
    bit         multi;
  } evt_t;
  evt_t sb[$];

  button_encoder_4x2_if bus();

  button_encoder_4x2 #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_evt(int c, bit p, logic [1:0] k, bit v, bit m);
    sb.push_back('{c, p, k, v, m});
  endtask

  task automatic step(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Event monitor: every press/release pulse must match the next predicted event.
  always @(negedge clk) begin
    evt_t e;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("evt_missing_at", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (bus.o_press || bus.o_release) begin
        if (sb.size() == 0) begin
          chk("unexp_evt", {bus.o_press, bus.o_release}, 2'b00);
        end else begin
          e = sb.pop_front();
          chk("evt_cyc", cyc, e.cyc);
          chk("evt_press", bus.o_press, e.press);
          chk("evt_release", bus.o_release, !e.press);
          chk("evt_key", bus.o_key, e.key);
          chk("evt_valid", bus.o_valid, e.valid);
          chk("evt_multi", bus.o_multi, e.multi);
        end
      end
    end
  end

  initial begin
    int n, m;
    rst = 1'b0;
    bus.i_btn = 4'b1111;
    #1 rst = 1'b1;
    step(2);
    chk("rst_key", bus.o_key, 2'd0);
    chk("rst_valid", bus.o_valid, 1'b0);
    chk("rst_multi", bus.o_multi, 1'b0);
    chk("rst_press", bus.o_press, 1'b0);
    chk("rst_release", bus.o_release, 1'b0);
    rst = 1'b0;
    step(3);

    // clean press and release of key 2
    n = cyc;
    bus.i_btn = 4'b1011;
    expect_evt(n + LAT, 1, 2'd2, 1, 0);
    step(10);
    bus.i_btn = 4'b1111;
    expect_evt(n + 10 + LAT, 0, 2'd2, 0, 0);
    step(12);

    // glitch of DB-1 cycles is discarded
    bus.i_btn = 4'b1110;
    step(DB - 1);
    bus.i_btn = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("glitch_valid", bus.o_valid, 1'b0);
    end
    step(1);

    // multi-key priority: 3 alone, then 3+1, then back to 3
    n = cyc;
    bus.i_btn = 4'b0111;
    expect_evt(n + LAT, 1, 2'd3, 1, 0);
    step(10);
    bus.i_btn = 4'b0101;
    step(LAT - 1);
    chk("multi_key_before", bus.o_key, 2'd3);
    chk("multi_flag_before", bus.o_multi, 1'b0);
    step(1);
    chk("multi_key", bus.o_key, 2'd1);
    chk("multi_flag", bus.o_multi, 1'b1);
    chk("multi_valid", bus.o_valid, 1'b1);
    step(3);
    bus.i_btn = 4'b0111;
    step(LAT);
    chk("back_key", bus.o_key, 2'd3);
    chk("back_multi", bus.o_multi, 1'b0);
    step(3);
    n = cyc;
    bus.i_btn = 4'b1111;
    expect_evt(n + LAT, 0, 2'd3, 0, 0);
    step(12);

    // async reset while HELD with the debounce count at 2
    n = cyc;
    bus.i_btn = 4'b1011;
    expect_evt(n + LAT, 1, 2'd2, 1, 0);
    step(10);
    bus.i_btn = 4'b1110;
    step(4);
    #1 rst = 1'b1;
    #1;
    chk("arst_key", bus.o_key, 2'd0);
    chk("arst_valid", bus.o_valid, 1'b0);
    chk("arst_multi", bus.o_multi, 1'b0);
    chk("arst_press", bus.o_press, 1'b0);
    chk("arst_release", bus.o_release, 1'b0);
    step(2);
    rst = 1'b0;
    n = cyc;
    expect_evt(n + LAT, 1, 2'd0, 1, 0);
    step(12);
    m = cyc;
    bus.i_btn = 4'b1111;
    expect_evt(m + LAT, 0, 2'd0, 0, 0);
    step(12);

    // long hold of key 1: auto-repeat only when the feature is built in
    n = cyc;
    bus.i_btn = 4'b1101;
    expect_evt(n + LAT, 1, 2'd1, 1, 0);
`ifdef BTN_REPEAT_EN
    for (int t = n + LAT + RD; t < n + 60 + LAT; t += RP)
      expect_evt(t, 1, 2'd1, 1, 0);
`endif
    expect_evt(n + 60 + LAT, 0, 2'd1, 0, 0);
    step(60);
    bus.i_btn = 4'b1111;
    step(14);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
